// File: rtl/fb_fifo_rd.sv
// Show-ahead FIFO drain into a registered 2-entry valid/ready skid buffer.
// Optional transfer counter on rd_count when FB_FIFO_RD_STATS_EN is defined.
module fb_fifo_rd #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_pop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [31:0]      rd_count
);

    localparam int unsigned CNT_W = 32;
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             pop_c;
    logic             xfer_c;

    // Pop only with room: TWO frees a slot only when the head leaves this cycle.
    always_comb begin
        pop_c  = rst_n & en & ~fifo_empty & ((state_q != TWO) | out_ready);
        xfer_c = (state_q != EMPTY) & out_ready;
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (pop_c) begin
                    state_d = ONE;
                    head_d  = fifo_data;
                end
            end
            ONE: begin
                if (pop_c && !xfer_c) begin
                    state_d = TWO;
                    tail_d  = fifo_data;
                end else if (!pop_c && xfer_c) begin
                    state_d = EMPTY;
                end else if (pop_c && xfer_c) begin
                    head_d = fifo_data;
                end
            end
            TWO: begin
                // Second entry moves up; a concurrent pop refills behind it.
                if (xfer_c) begin
                    head_d = tail_q;
                    if (pop_c) begin
                        tail_d = fifo_data;
                    end else begin
                        state_d = ONE;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
        end
    end

    // Second entry is only read when state says it is occupied, so no reset.
    always_ff @(posedge clk) begin
        tail_q <= tail_d;
    end

    assign fifo_pop  = pop_c;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;

`ifdef FB_FIFO_RD_STATS_EN
    logic [CNT_W-1:0] rd_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q <= '0;
        end else if (xfer_c) begin
            rd_count_q <= rd_count_q + CNT_W'(1);
        end
    end

    assign rd_count = rd_count_q;
`else
    assign rd_count = CNT_W'(0);
`endif

endmodule

// File: doc/fb_fifo_rd.md
FB_FIFO_RD -- requirements
Module: fb_fifo_rd

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data word width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port en, input, 1 bit: drain enable; when low, no new pops are issued.
REQ-005 SHALL have port fifo_empty, input, 1 bit: FIFO holds no word.
REQ-006 SHALL have port fifo_data, input, WIDTH bits: FIFO head word, show-ahead, valid whenever fifo_empty=0.
REQ-007 SHALL have port fifo_pop, output, 1 bit: consume the head word this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a word.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the word this cycle.
REQ-010 SHALL have port out_data, output, WIDTH bits: current output word.
REQ-011 SHALL have port rd_count, output, 32 bits: count of words transferred downstream.

Function
REQ-012 SHALL contain a 2-entry internal buffer with FSM states EMPTY (0 words), ONE (1 word), TWO (2 words).
REQ-013 SHALL drive fifo_pop = en & ~fifo_empty & (state!=TWO | out_ready) combinationally.
REQ-014 SHALL capture fifo_data into the buffer tail on every cycle where fifo_pop=1.
REQ-015 SHALL drive out_valid=1 exactly when the state is not EMPTY, from registered state only.
REQ-016 SHALL drive out_data from the buffer head register, with no combinational path from fifo_data.
REQ-017 SHALL treat a transfer as out_valid & out_ready, which removes the head word.
REQ-018 SHALL make a popped word visible on out_valid/out_data one cycle after the pop (latency 1) when the buffer was EMPTY.
REQ-019 SHALL apply these transitions:
- EMPTY -pop-> ONE.
- ONE: pop & ~transfer -> TWO; ~pop & transfer -> EMPTY; pop & transfer, or neither -> ONE.
- TWO: transfer & ~pop -> ONE; transfer & pop -> TWO; no transfer -> TWO (no pop possible).
REQ-020 SHALL, on simultaneous pop and transfer, shift the second entry to the head and write the new word behind it, preserving order.
REQ-021 SHALL sustain one transfer per cycle when fifo_empty=0, en=1 and out_ready=1 continuously.
REQ-022 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, after en falls, keep presenting and transferring already-buffered words; only pops stop.
REQ-024 SHALL never pop while fifo_empty=1, and SHALL never lose or duplicate a word.
REQ-025 SHALL increment rd_count by 1 per transfer, wrapping from 0xFFFFFFFF to 0 (when the feature in REQ-030 is compiled in).

Reset
REQ-026 SHALL asynchronously force, while rst_n=0: state=EMPTY, out_valid=0, out_data=0, rd_count=0.
REQ-027 SHALL hold fifo_pop=0 while rst_n=0.
REQ-028 SHALL discard buffered words on reset mid-operation and resume with the first rising clk edge after rst_n returns high.
REQ-029 SHALL not reset buffer data contents other than the head register.

Configuration
REQ-030 SHALL implement the rd_count counter only when macro FB_FIFO_RD_STATS_EN is defined.
REQ-031 SHALL, without FB_FIFO_RD_STATS_EN, tie rd_count to constant 0 with no counter flops; all other behaviour is identical.

Verification
REQ-032 SHALL cover streaming: FIFO holds 0x11,0x22,0x33; en=1, out_ready=1 -> pops on cycles 0-2; out_data 0x11,0x22,0x33 on cycles 1-3; rd_count=3.
REQ-033 SHALL cover backpressure: out_ready=0 with FIFO non-empty -> exactly 2 pops, then fifo_pop=0; out_data holds the first word; after out_ready=1, words leave in order with no gap.
REQ-034 SHALL cover simultaneous pop and transfer: in state TWO with out_ready=1 and FIFO non-empty -> fifo_pop=1, state remains TWO, order preserved.
REQ-035 SHALL cover enable drop: en falls with 2 words buffered and out_ready=1 -> both words transfer, no further pops, out_valid=0 afterwards.
REQ-036 SHALL cover mid-stream reset: rst_n=0 with 2 words buffered -> out_valid=0, fifo_pop=0, rd_count=0 immediately, without waiting for a clk edge.
REQ-037 SHALL cover counter wrap: with FB_FIFO_RD_STATS_EN defined, rd_count preloaded via force to 0xFFFFFFFF, then 1 transfer -> rd_count=0; without the macro, rd_count=0 throughout.
